// File: rtl/scan_sequencer.sv
// scan_sequencer: programmable-rate 3-bit select index generator for a one-hot row/LED decoder
module scan_sequencer #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [2:0]       load_val,
  input  logic [DIV_W-1:0] div,
  output logic [2:0]       sel,
  output logic             dir,
  output logic             tick,
  output logic             wrap
);
  typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_t;
  logic [2:0]       sel_q, sel_d;
  dir_t             dir_q, dir_d;
  logic [DIV_W-1:0] pc_q, pc_d;
  logic             tick_q, tick_d, wrap_q, wrap_d;
  logic             go_up;
  // bounce keeps rising until 7 while UP, and turns back up only after reaching 0 while DOWN
  assign go_up = (mode == 2'b00) || (mode == 2'b10 && (dir_q == UP ? sel_q != 3'd7 : sel_q == 3'd0));
  always_comb begin
    sel_d  = sel_q;
    dir_d  = dir_q;
    pc_d   = pc_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (load) begin
      sel_d = load_val;
      pc_d  = '0;
      dir_d = mode == 2'b00 ? UP : mode == 2'b01 ? DOWN : dir_q;
    end else if (en && mode != 2'b11) begin
      pc_d = pc_q >= div ? '0 : pc_q + 1'b1;
      if (pc_q >= div) begin
        tick_d = 1'b1;
        sel_d  = go_up ? sel_q + 3'd1 : sel_q - 3'd1;
        dir_d  = go_up ? UP : DOWN;
        wrap_d = mode[1] ? (dir_q != dir_d) : (sel_q == (go_up ? 3'd7 : 3'd0));
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      dir_q  <= UP;
      pc_q   <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      dir_q  <= dir_d;
      pc_q   <= pc_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end
  assign sel  = sel_q;
  assign dir  = dir_q;
  assign tick = tick_q;
  assign wrap = wrap_q;
endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Generates the 3-bit select index that drives the team's 3-to-8 one-hot decoder (LED chaser / row-scan front end).
- Steps the index at a programmable rate, in one of four modes: count up, count down, bounce (ping-pong 0..7..0), or hold.
- Supports synchronous load of a start position.
- Emits a one-cycle step pulse and an end-of-range pulse, so downstream logic can align to index changes.

Parameters:
- DIV_W, 4, width of the prescaler divide value and prescaler counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; low freezes prescaler and index.
- mode  input  2  00=up, 01=down, 10=bounce, 11=hold.
- load  input  1  synchronous load strobe.
- load_val  input  3  index value loaded when load=1.
- div  input  DIV_W  step period minus one: one step every div+1 enabled cycles.
- sel  output  3  current index, connects to decoder in[2:0].
- dir  output  1  current direction, 1=up, 0=down.
- tick  output  1  high for exactly the one cycle in which sel shows a newly stepped value.
- wrap  output  1  high with tick when the step crossed an end: 7->0 or 0->7 wrap, or a bounce reversal.

Behaviour:
- Reset (rst_n=0, asynchronous): sel=0, dir=1 (state UP), prescaler pc=0, tick=0, wrap=0. These values hold until the first rising edge after rst_n deasserts.
- Reset mid-operation: all state clears immediately, regardless of clock. There is no partial step and no pulse after release.
- All outputs are registered. tick and wrap are default-0 every cycle unless a step occurs on that edge.
- Priority at each edge, highest first: load > (en=0 or mode=11) > step logic.
- load=1:
  - sel<=load_val, pc<=0, tick=0, wrap=0.
  - dir is unchanged, except: mode=00 forces dir=1, mode=01 forces dir=0.
  - en is ignored.
- Hold (en=0 or mode=11): sel, pc and dir hold; tick=0, wrap=0. The prescaler does not reset, so resuming continues the count.
- Prescaler (en=1, mode!=11, load=0):
  - If pc>=div: step, and pc<=0.
  - Else pc<=pc+1.
  - The >= comparison guarantees a step on the next enabled edge if div is lowered below pc mid-count. No lock-up.
  - div=0 steps every enabled cycle.
- Step, mode=00: dir<=1, sel<=sel+1 modulo 8. wrap=1 when old sel=7 (new sel=0).
- Step, mode=01: dir<=0, sel<=sel-1 modulo 8. wrap=1 when old sel=0 (new sel=7).
- Step, mode=10 (bounce FSM, states UP/DOWN held in dir):
  - UP, sel<7: sel+1, stay UP.
  - UP, sel=7: sel<=6, go DOWN, wrap=1.
  - DOWN, sel>0: sel-1, stay DOWN.
  - DOWN, sel=0: sel<=1, go UP, wrap=1.
- Every step asserts tick=1 on the same edge that sel updates.
- Mode change mid-run takes effect at the next step only. pc is not disturbed. On entry to bounce, the current dir selects the starting FSM state.
- Latency: with en held high from a synchronous start at pc=0, the first sel change appears on the (div+1)-th enabled rising edge. Steady state is exactly div+1 cycles between tick pulses.
- Index arithmetic is 3-bit unsigned with natural wrap in up/down modes. The bounce mode never wraps the index.

Test Plan:
- Reset, then mode=00, div=0, en=1 for 10 cycles -> sel 0,1,...,7,0,1. tick high every cycle. wrap high only on the cycle sel=0 after 7.
- mode=00, div=3, en=1 -> sel increments every 4 cycles. tick is a single-cycle pulse aligned to each change. Drop en for 5 cycles mid-count -> sel frozen, no tick, count resumes with remaining prescale.
- mode=01, load=1 with load_val=2, then div=0 -> sel 2,1,0,7,6. wrap only on the 0->7 step. dir=0.
- mode=10, load_val=5, div=0, dir=1 -> sel 5,6,7,6,5,...,0,1. wrap on 7->6 and 0->1. dir toggles at those steps.
- div=7 with pc at 6, change div to 2 -> step on the next enabled edge, then every 3 cycles. Assert load and en together -> load wins, sel=load_val, tick=0.
- Assert rst_n=0 asynchronously between edges mid-run at sel=4, dir=0 -> sel=0, dir=1, tick=0, wrap=0 immediately. No pulses on release.
